// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Round-robin Wishbone-classic arbiter that shares the single I/O controller
//   slave port among NM bus masters (CPU, DMA, debug). One master owns the
//   slave for the whole of its cyc; the grant is registered, so arbitration
//   costs one cycle, and there is always one idle cycle between tenures so
//   the slave sees cyc drop.
//
//   Optional feature, enabled by defining IO_ARB_WATCHDOG_EN:
//     a watchdog counts cycles of s_stb_o without s_ack_i. At TIMEOUT it
//     answers the owner with a one-cycle err, drops the slave strobes and
//     parks in HOLD until the owner releases cyc. Without the macro there is
//     no counter and m_err_o is constant 0.
//
// Ports
//   clk_i    : system clock, rising edge
//   rst_i    : asynchronous reset, active low
//   m_cyc_i  : per-master cyc            [NM]
//   m_stb_i  : per-master stb            [NM]
//   m_we_i   : per-master we             [NM]
//   m_adr_i  : per-master address        [NM*AW], master k at [k*AW +: AW]
//   m_dat_i  : per-master write data     [NM*DW]
//   m_sel_i  : per-master byte selects   [NM*4]
//   m_dat_o  : read data broadcast to all masters
//   m_ack_o  : ack, only to the granted master
//   m_err_o  : err, only to the granted master (watchdog build)
//   s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o : to the slave
//   s_dat_i  : read data from the slave
//   s_ack_i  : ack from the slave
//   grant_o  : one-hot current owner, 0 when idle
module io_bus_arbiter #(
   parameter int NM      = 3,
   parameter int AW      = 17,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NM-1:0]    m_cyc_i,
   input  logic [NM-1:0]    m_stb_i,
   input  logic [NM-1:0]    m_we_i,
   input  logic [NM*AW-1:0] m_adr_i,
   input  logic [NM*DW-1:0] m_dat_i,
   input  logic [NM*4-1:0]  m_sel_i,
   output logic [DW-1:0]    m_dat_o,
   output logic [NM-1:0]    m_ack_o,
   output logic [NM-1:0]    m_err_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [AW-1:0]    s_adr_o,
   output logic [DW-1:0]    s_dat_o,
   output logic [3:0]       s_sel_o,
   input  logic [DW-1:0]    s_dat_i,
   input  logic             s_ack_i,
   output logic [NM-1:0]    grant_o
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;

`ifdef IO_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
`else
   typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

   state_t        state, state_nx;
   logic [NM-1:0] grant, grant_nx;
   logic [IW-1:0] gidx, gidx_nx;
   logic [IW-1:0] last, last_nx;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   logic          in_grant;
   logic          req_stb;
   logic          timeout;

   // Round-robin search: first requester after the previous owner.
   always_comb begin
      logic [IW-1:0] cand;
      pick_vld = 1'b0;
      pick_idx = last;
      cand     = last;
      for (int i = 1; i <= NM; i++) begin
         cand = IW'((int'(last) + i) % NM);
         if (!pick_vld && m_cyc_i[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign in_grant = (state == GRANT);
   assign req_stb  = in_grant & m_cyc_i[gidx] & m_stb_i[gidx];

`ifdef IO_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;

   // An ack in the timeout cycle wins: timeout requires !s_ack_i.
   assign timeout = req_stb & ~s_ack_i & (wd_cnt == CW'(TIMEOUT));
   assign m_err_o = timeout ? grant : '0;

   // Cleared outside GRANT so every tenure starts from 0; saturates at
   // TIMEOUT, where the FSM leaves GRANT anyway.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wd_cnt <= '0;
      end else if (!in_grant || s_ack_i) begin
         wd_cnt <= '0;
      end else if (req_stb && (wd_cnt != CW'(TIMEOUT))) begin
         wd_cnt <= wd_cnt + CW'(1);
      end
   end
`else
   assign timeout = 1'b0;
   // TIMEOUT only matters with the watchdog; this term is constant 0.
   assign m_err_o = {NM{TIMEOUT < 0}};
`endif

   // FSM state and grant registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         grant <= '0;
         gidx  <= '0;
         last  <= IW'(NM - 1);
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         gidx  <= gidx_nx;
         last  <= last_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      gidx_nx  = gidx;
      last_nx  = last;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nx = GRANT;
               gidx_nx  = pick_idx;
               grant_nx = NM'(1) << pick_idx;
            end
         end
         GRANT: begin
`ifdef IO_ARB_WATCHDOG_EN
            if (timeout) begin
               state_nx = HOLD;
            end else
`endif
            if (!m_cyc_i[gidx]) begin
               state_nx = IDLE;
               grant_nx = '0;
               last_nx  = gidx;
            end
         end
`ifdef IO_ARB_WATCHDOG_EN
         HOLD: begin
            if (!m_cyc_i[gidx]) begin
               state_nx = IDLE;
               grant_nx = '0;
               last_nx  = gidx;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Slave-side mux. Everything reads 0 outside a tenure, so an asynchronous
   // reset clears the bus immediately. m_dat_o follows s_dat_i in the same
   // cycle as the combinational ack so the owner can latch both together.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      m_dat_o = '0;
      m_ack_o = '0;
      if (in_grant) begin
         s_cyc_o       = m_cyc_i[gidx] & ~timeout;
         s_stb_o       = req_stb & ~timeout;
         s_we_o        = m_we_i[gidx];
         s_adr_o       = m_adr_i[gidx*AW +: AW];
         s_dat_o       = m_dat_i[gidx*DW +: DW];
         s_sel_o       = m_sel_i[gidx*4 +: 4];
         m_dat_o       = s_dat_i;
         // A late ack (owner stb already low) reaches nobody.
         m_ack_o[gidx] = req_stb & s_ack_i;
      end
   end

   assign grant_o = grant;

endmodule

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
module tb_io_bus_arbiter;
   localparam int NM  = 3;
   localparam int AW  = 17;
   localparam int DW  = 32;
   localparam int TMO = 8;
`ifdef IO_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [NM-1:0]    m_cyc_i = '0;
   logic [NM-1:0]    m_stb_i = '0;
   logic [NM-1:0]    m_we_i  = '0;
   logic [NM*AW-1:0] m_adr_i = '0;
   logic [NM*DW-1:0] m_dat_i = '0;
   logic [NM*4-1:0]  m_sel_i = '0;
   logic [DW-1:0]    s_dat_i = '0;
   logic             s_ack_i = 1'b0;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
   logic             s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [3:0]       s_sel_o;

   io_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   wire [10:0] obs_ctl  = {grant_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o};
   wire [85:0] obs_path = {s_we_o, s_adr_o, s_dat_o, s_sel_o, m_dat_o};

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the bus, who owned it last, whether the owner
   // was timed out, and how long the current strobe has waited.
   int            own, mlast, mwait;
   bit            mhold, e_to;
   logic [NM-1:0] e_grant, e_ack, e_err;
   logic          e_cyc, e_stb;
   logic [10:0]   e_ctl;
   logic [85:0]   e_path;

   task automatic model_reset();
      own = -1; mlast = NM - 1; mwait = 0; mhold = 1'b0;
   endtask

   task automatic model_eval();
      bit stb;
      e_grant = '0; e_ack = '0; e_err = '0; e_cyc = 1'b0; e_stb = 1'b0;
      e_path = '0; e_to = 1'b0;
      if (own >= 0) e_grant[own] = 1'b1;
      if (own >= 0 && !mhold) begin
         stb   = m_cyc_i[own] && m_stb_i[own];
         e_to  = WD && stb && !s_ack_i && (mwait == TMO);
         e_cyc = m_cyc_i[own] && !e_to;
         e_stb = stb && !e_to;
         if (stb && s_ack_i) e_ack[own] = 1'b1;
         if (e_to) e_err[own] = 1'b1;
         e_path = {m_we_i[own], m_adr_i[own*AW +: AW], m_dat_i[own*DW +: DW],
                   m_sel_i[own*4 +: 4], s_dat_i};
      end
      e_ctl = {e_grant, e_ack, e_err, e_cyc, e_stb};
   endtask

   task automatic model_clock();
      bit stb, found;
      if (own < 0) begin
         found = 1'b0;
         for (int i = 1; i <= NM; i++) begin
            if (!found && m_cyc_i[(mlast + i) % NM]) begin
               found = 1'b1;
               own   = (mlast + i) % NM;
               mwait = 0;
            end
         end
      end else if (mhold) begin
         if (!m_cyc_i[own]) begin mlast = own; own = -1; mhold = 1'b0; end
      end else begin
         stb = m_cyc_i[own] && m_stb_i[own];
         if (s_ack_i) mwait = 0;
         else if (stb) mwait++;
         if (e_to) mhold = 1'b1;
         else if (!m_cyc_i[own]) begin mlast = own; own = -1; end
      end
   endtask

   task automatic drive(input int k, input bit cyc, input bit stb, input bit we,
                        input logic [AW-1:0] adr);
      m_cyc_i[k] = cyc;
      m_stb_i[k] = stb;
      m_we_i[k]  = we;
      m_adr_i[k*AW +: AW] = adr;
      m_dat_i[k*DW +: DW] = $urandom;
      m_sel_i[k*4 +: 4]   = 4'($urandom);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      #1;
      total++;
      if (obs_ctl !== 11'd0) begin bad++; $display("FAIL reset_ctl got=%h need=0", obs_ctl); end
      total++;
      if (obs_path !== 86'd0) begin bad++; $display("FAIL reset_path got=%h need=0", obs_path); end
      rst_i = 1'b1;
      model_reset();
      @(negedge clk_i);
   endtask

   task automatic test_rr_order();
      int            ten[NM];
      logic [NM-1:0] order[$];
      logic [NM-1:0] exp_order[4];
      logic [NM-1:0] prev;
      int            gap, n;
      exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
      prev = '0; gap = 0; n = 0;
      for (int k = 0; k < NM; k++) ten[k] = 0;
      while (order.size() < 4 && n < 60) begin
         for (int k = 0; k < NM; k++) begin
            if (!m_cyc_i[k]) m_cyc_i[k] = 1'b1;
            else if (own == k && ten[k] >= 2) begin m_cyc_i[k] = 1'b0; ten[k] = 0; end
         end
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL rr_ctl n=%0d got=%h need=%h", n, obs_ctl, e_ctl); end
         if (grant_o !== '0 && prev === '0) begin
            order.push_back(grant_o);
            total++;
            if (gap != 1) begin bad++; $display("FAIL rr_gap n=%0d got=%0d need=1", n, gap); end
         end
         gap  = (grant_o === '0) ? gap + 1 : 0;
         prev = grant_o;
         if (own >= 0 && m_cyc_i[own]) ten[own]++;
         model_clock();
         @(negedge clk_i);
         n++;
      end
      total++;
      if (order.size() != 4) begin
         bad++; $display("FAIL rr_count got=%0d need=4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] !== exp_order[i]) begin
               bad++; $display("FAIL rr_order i=%0d got=%b need=%b", i, order[i], exp_order[i]);
            end
         end
      end
      m_cyc_i = '0;
      for (int c = 0; c < 2; c++) begin
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL rr_drain_ctl got=%h need=%h", obs_ctl, e_ctl); end
         model_clock();
         @(negedge clk_i);
      end
   endtask

   task automatic test_read();
      for (int c = 0; c < 8; c++) begin
         case (c)
            0: drive(1, 1, 1, 0, 17'h01000);
            1: begin drive(0, 1, 1, 1, 17'h00ABC); s_ack_i = 1'b1; s_dat_i = 32'h0000BEEF; end
            2: begin drive(1, 0, 0, 0, 17'h0); s_ack_i = 1'b0; end
            4: begin m_stb_i[0] = 1'b0; s_ack_i = 1'b1; end
            5: begin m_stb_i[0] = 1'b1; s_ack_i = 1'b1; end
            6: begin drive(0, 0, 0, 0, 17'h0); s_ack_i = 1'b0; end
            default: ;
         endcase
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL read_ctl c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         total++;
         if (obs_path !== e_path) begin bad++; $display("FAIL read_path c=%0d got=%h need=%h", c, obs_path, e_path); end
         if (c == 1) begin
            total++;
            if (m_ack_o !== 3'b010 || m_dat_o !== 32'h0000BEEF || s_adr_o !== 17'h01000) begin
               bad++; $display("FAIL read_beef ack=%b dat=%h adr=%h need 010/0000beef/01000", m_ack_o, m_dat_o, s_adr_o);
            end
         end
         if (c == 4) begin
            total++;
            if (m_ack_o !== 3'b000) begin bad++; $display("FAIL late_ack got=%b need=000", m_ack_o); end
         end
         model_clock();
         @(negedge clk_i);
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      logic [AW-1:0] adr_list[3];
      adr_list = '{17'h02004, 17'h02008, 17'h0200C};
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         if (c == 0) drive(2, 1, 1, 1, adr_list[0]);
         if (c == 1) drive(0, 1, 0, 0, 17'h0);
         if (c >= 1 && c <= 6) begin
            s_ack_i = (c % 2 == 0);
            if (c == 3 || c == 5) drive(2, 1, 1, 1, adr_list[(c - 1) / 2]);
         end
         if (c == 7) begin drive(2, 0, 0, 0, 17'h0); s_ack_i = 1'b0; end
         if (c == 10) drive(0, 0, 0, 0, 17'h0);
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL b2b_ctl c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         total++;
         if (obs_path !== e_path) begin bad++; $display("FAIL b2b_path c=%0d got=%h need=%h", c, obs_path, e_path); end
         if (c >= 1 && c <= 7) begin
            total++;
            if (grant_o !== 3'b100) begin bad++; $display("FAIL b2b_lock c=%0d got=%b need=100", c, grant_o); end
         end
         if (m_ack_o === 3'b100) acks++;
         if (c == 9) begin
            total++;
            if (grant_o !== 3'b001) begin bad++; $display("FAIL b2b_next got=%b need=001", grant_o); end
         end
         model_clock();
         @(negedge clk_i);
      end
      total++;
      if (acks != 3) begin bad++; $display("FAIL b2b_acks got=%0d need=3", acks); end
   endtask

`ifdef IO_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      for (int c = 0; c < 26; c++) begin
         if (c == 0) begin drive(1, 1, 1, 0, 17'h01234); drive(2, 1, 0, 1, 17'h02000); s_ack_i = 1'b0; end
         if (c == 11) drive(1, 0, 0, 0, 17'h0);
         if (c == 13) drive(2, 1, 1, 1, 17'h02010);
         s_ack_i = (c == 21);
         if (c == 23) drive(2, 0, 0, 0, 17'h0);
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL wd_ctl c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         total++;
         if (obs_path !== e_path) begin bad++; $display("FAIL wd_path c=%0d got=%h need=%h", c, obs_path, e_path); end
         if (c >= 1 && c <= 8) begin
            total++;
            if (m_err_o !== 3'b000 || s_cyc_o !== 1'b1) begin
               bad++; $display("FAIL wd_early c=%0d err=%b cyc=%b need 000/1", c, m_err_o, s_cyc_o);
            end
         end
         if (c == 9) begin
            total++;
            if (m_err_o !== 3'b010 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
               bad++; $display("FAIL wd_timeout err=%b cyc=%b stb=%b need 010/0/0", m_err_o, s_cyc_o, s_stb_o);
            end
         end
         if (c == 10) begin
            total++;
            if (m_err_o !== 3'b000 || s_cyc_o !== 1'b0 || grant_o !== 3'b010) begin
               bad++; $display("FAIL wd_hold err=%b cyc=%b grant=%b need 000/0/010", m_err_o, s_cyc_o, grant_o);
            end
         end
         if (c == 13) begin
            total++;
            if (grant_o !== 3'b100) begin bad++; $display("FAIL wd_next got=%b need=100", grant_o); end
         end
         if (c == 21 || c == 22) begin
            total++;
            if (m_err_o !== 3'b000 || m_ack_o !== ((c == 21) ? 3'b100 : 3'b000)) begin
               bad++; $display("FAIL wd_ack_wins c=%0d ack=%b err=%b", c, m_ack_o, m_err_o);
            end
         end
         model_clock();
         @(negedge clk_i);
      end
   endtask
`else
   task automatic test_no_watchdog();
      for (int c = 0; c < 26; c++) begin
         if (c == 0) begin drive(1, 1, 1, 0, 17'h01234); drive(2, 1, 0, 1, 17'h02000); s_ack_i = 1'b0; end
         if (c == 21) drive(1, 0, 0, 0, 17'h0);
         if (c == 24) drive(2, 0, 0, 0, 17'h0);
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL nowd_ctl c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         if (c >= 1 && c <= 20) begin
            total++;
            if (m_err_o !== 3'b000 || s_cyc_o !== 1'b1 || grant_o !== 3'b010) begin
               bad++; $display("FAIL nowd_stall c=%0d err=%b cyc=%b grant=%b", c, m_err_o, s_cyc_o, grant_o);
            end
         end
         if (c == 23) begin
            total++;
            if (grant_o !== 3'b100) begin bad++; $display("FAIL nowd_next got=%b need=100", grant_o); end
         end
         model_clock();
         @(negedge clk_i);
      end
   endtask
`endif

   task automatic test_async_reset();
      for (int c = 0; c < 2; c++) begin
         if (c == 0) drive(2, 1, 1, 1, 17'h03000);
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL arst_pre c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         model_clock();
         @(negedge clk_i);
      end
      #1;
      total++;
      if (s_cyc_o !== 1'b1 || grant_o !== 3'b100) begin
         bad++; $display("FAIL arst_busy cyc=%b grant=%b need 1/100", s_cyc_o, grant_o);
      end
      #2; rst_i = 1'b0; #1;
      total++;
      if (obs_ctl !== 11'd0) begin bad++; $display("FAIL arst_ctl got=%h need=0", obs_ctl); end
      total++;
      if (obs_path !== 86'd0) begin bad++; $display("FAIL arst_path got=%h need=0", obs_path); end
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int k = 0; k < NM; k++) drive(k, 1, 0, 0, 17'h0);
      for (int c = 0; c < 4; c++) begin
         if (c == 2) m_cyc_i = '0;
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL arst_post c=%0d got=%h need=%h", c, obs_ctl, e_ctl); end
         if (c == 1) begin
            total++;
            if (grant_o !== 3'b001) begin bad++; $display("FAIL arst_first got=%b need=001", grant_o); end
         end
         model_clock();
         @(negedge clk_i);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < NM; k++) begin
            if (m_cyc_i[k]) begin
               if ($urandom_range(0, 5) == 0) drive(k, 0, 0, 0, AW'($urandom));
               else drive(k, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
            end else if ($urandom_range(0, 2) == 0) begin
               drive(k, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
            end
         end
         s_ack_i = 1'($urandom_range(0, 1));
         s_dat_i = $urandom;
         #1; model_eval();
         total++;
         if (obs_ctl !== e_ctl) begin bad++; $display("FAIL rand_ctl n=%0d got=%h need=%h", n, obs_ctl, e_ctl); end
         total++;
         if (obs_path !== e_path) begin bad++; $display("FAIL rand_path n=%0d got=%h need=%h", n, obs_path, e_path); end
         model_clock();
         @(negedge clk_i);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rr_order();
      test_read();
      test_back_to_back();
`ifdef IO_ARB_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
